// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker. Learns the LFSR state from the received
// stream in SEARCH, then free-runs its own copy in LOCKED and flags every bit
// that disagrees. Loss of lock is judged per window of valid bits.
module prbs_checker #(
   parameter int             N           = 7,
   parameter logic [N-1:0]   TAPS        = 7'b1100000,
   parameter int             LOCK_COUNT  = 16,
   parameter int             WINDOW      = 64,
   parameter int             LOSS_THRESH = 4,
   parameter int             CNT_W       = 32
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             data_i,
   input  logic             valid_i,
   input  logic             clear_i,
   output logic             locked_o,
   output logic             err_o,
   output logic [CNT_W-1:0] err_count_o,
   output logic [CNT_W-1:0] bit_count_o
);

   localparam int FILL_W  = $clog2(N + 1);
   localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
   localparam int WIN_W   = $clog2(WINDOW);
   localparam int WERR_W  = $clog2(LOSS_THRESH + 1);

   localparam logic [FILL_W-1:0]  FILL_FULL  = FILL_W'(N);
   localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
   localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WINDOW - 1);
   localparam logic [WERR_W-1:0]  WERR_LOSS  = WERR_W'(LOSS_THRESH);

   typedef enum logic {S_SEARCH, S_LOCKED} state_t;

   state_t              r_state, w_state_nxt;
   logic [N-1:0]        r_h, w_h_nxt;
   logic [FILL_W-1:0]   r_fill, w_fill_nxt;
   logic [MATCH_W-1:0]  r_match, w_match_nxt;
   logic [WIN_W-1:0]    r_win, w_win_nxt;
   logic [WERR_W-1:0]   r_werr, w_werr_nxt, w_werr_new;
   logic                r_err, w_err_nxt;
   logic [CNT_W-1:0]    r_err_cnt, w_err_cnt_nxt;
   logic [CNT_W-1:0]    r_bit_cnt, w_bit_cnt_nxt;
   logic                w_pred, w_bit_inc, w_err_inc;

   // Next bit predicted from the history (newest bit in h[0]).
   assign w_pred = ^(r_h & TAPS);

   // Next-state logic: search/lock FSM, history, window tracking, counters.
   always_comb begin
      w_state_nxt = r_state;
      w_h_nxt     = r_h;
      w_fill_nxt  = r_fill;
      w_match_nxt = r_match;
      w_win_nxt   = r_win;
      w_werr_nxt  = r_werr;
      w_werr_new  = r_werr;
      w_err_nxt   = 1'b0;
      w_bit_inc   = 1'b0;
      w_err_inc   = 1'b0;
      case (r_state)
         S_SEARCH: begin
            if (valid_i) begin
               w_h_nxt = {r_h[N-2:0], data_i};
               if (r_fill != FILL_FULL) begin
                  w_fill_nxt = r_fill + 1'b1;
               end else if ((w_pred == data_i) && (r_h != '0)) begin
                  // An all-zero history never counts, so a dead line cannot lock.
                  if (r_match == MATCH_LAST) begin
                     w_state_nxt = S_LOCKED;
                     w_match_nxt = '0;
                     w_win_nxt   = '0;
                     w_werr_nxt  = '0;
                  end else begin
                     w_match_nxt = r_match + 1'b1;
                  end
               end else begin
                  w_match_nxt = '0;
               end
            end
         end
         S_LOCKED: begin
            if (valid_i) begin
               // Free-run on the prediction so a received error does not propagate.
               w_h_nxt   = {r_h[N-2:0], w_pred};
               w_bit_inc = 1'b1;
               if (data_i != w_pred) begin
                  w_err_nxt  = 1'b1;
                  w_err_inc  = 1'b1;
                  w_werr_new = r_werr + 1'b1;
               end
               // Threshold is checked before the window wrap.
               if (w_werr_new == WERR_LOSS) begin
                  w_state_nxt = S_SEARCH;
                  w_fill_nxt  = '0;
                  w_match_nxt = '0;
                  w_win_nxt   = '0;
                  w_werr_nxt  = '0;
               end else if (r_win == WIN_LAST) begin
                  w_win_nxt  = '0;
                  w_werr_nxt = '0;
               end else begin
                  w_win_nxt  = r_win + 1'b1;
                  w_werr_nxt = w_werr_new;
               end
            end
         end
         default: w_state_nxt = S_SEARCH;
      endcase

      // Saturating statistics; clear wins over a same-cycle increment.
      w_err_cnt_nxt = r_err_cnt;
      w_bit_cnt_nxt = r_bit_cnt;
      if (clear_i) begin
         w_err_cnt_nxt = '0;
         w_bit_cnt_nxt = '0;
      end else begin
         if (w_err_inc && (r_err_cnt != '1)) w_err_cnt_nxt = r_err_cnt + 1'b1;
         if (w_bit_inc && (r_bit_cnt != '1)) w_bit_cnt_nxt = r_bit_cnt + 1'b1;
      end
   end

   // State register for FSM, history, window and statistics.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_state   <= S_SEARCH;
         r_h       <= '0;
         r_fill    <= '0;
         r_match   <= '0;
         r_win     <= '0;
         r_werr    <= '0;
         r_err     <= 1'b0;
         r_err_cnt <= '0;
         r_bit_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_h       <= w_h_nxt;
         r_fill    <= w_fill_nxt;
         r_match   <= w_match_nxt;
         r_win     <= w_win_nxt;
         r_werr    <= w_werr_nxt;
         r_err     <= w_err_nxt;
         r_err_cnt <= w_err_cnt_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
      end
   end

   assign locked_o    = (r_state == S_LOCKED);
   assign err_o       = r_err;
   assign err_count_o = r_err_cnt;
   assign bit_count_o = r_bit_cnt;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker with the default PRBS7 parameters.
module tb_prbs_checker;

   localparam int CNT_W = 32;

   logic             clk = 1'b0;
   logic             reset_i = 1'b1;
   logic             data_i = 1'b0;
   logic             valid_i = 1'b0;
   logic             clear_i = 1'b0;
   logic             locked_o;
   logic             err_o;
   logic [CNT_W-1:0] err_count_o;
   logic [CNT_W-1:0] bit_count_o;

   logic [6:0] g = 7'h01;
   int         n_vec = 0;
   int         n_err = 0;
   logic       err_seen, lock_seen, err_inval;
   logic       b;

   prbs_checker dut (
      .clk_i       (clk),
      .reset_i     (reset_i),
      .data_i      (data_i),
      .valid_i     (valid_i),
      .clear_i     (clear_i),
      .locked_o    (locked_o),
      .err_o       (err_o),
      .err_count_o (err_count_o),
      .bit_count_o (bit_count_o)
   );

   always #5 clk = ~clk;

   // Watchdog in case anything stalls.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chkn(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference PRBS7 generator: x^7 + x^6 + 1, seed 7'h01.
   task automatic next_prbs(output logic o);
      o = g[6] ^ g[5];
      g = {g[5:0], o};
   endtask

   task automatic step(input logic d, input logic v);
      data_i  = d;
      valid_i = v;
      @(posedge clk);
      #1;
      if (err_o === 1'b1) err_seen = 1'b1;
      if (locked_o === 1'b1) lock_seen = 1'b1;
      if (!v && err_o !== 1'b0) err_inval = 1'b1;
   endtask

   task automatic prbs_bits(input int n);
      logic x;
      for (int i = 0; i < n; i++) begin
         next_prbs(x);
         step(x, 1'b1);
      end
   endtask

   initial begin
      err_seen = 0; lock_seen = 0; err_inval = 0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk1("rst_locked", locked_o, 1'b0);
      chk1("rst_err", err_o, 1'b0);
      chkn("rst_errcnt", err_count_o, 32'd0);
      chkn("rst_bitcnt", bit_count_o, 32'd0);
      reset_i = 1'b0;

      // Clean PRBS7: lock after exactly 23 valid bits
      prbs_bits(22);
      chk1("t1_nolock_22", lock_seen, 1'b0);
      prbs_bits(1);
      chk1("t1_lock_23", locked_o, 1'b1);
      chkn("t1_bitcnt_at_lock", bit_count_o, 32'd0);
      prbs_bits(10);
      chkn("t1_bitcnt_10", bit_count_o, 32'd10);
      chkn("t1_errcnt_0", err_count_o, 32'd0);
      chk1("t1_no_err", err_seen, 1'b0);

      // Single inverted bit
      next_prbs(b);
      step(~b, 1'b1);
      chk1("t2_err_pulse", err_o, 1'b1);
      chkn("t2_errcnt_1", err_count_o, 32'd1);
      chk1("t2_locked", locked_o, 1'b1);
      chkn("t2_bitcnt_11", bit_count_o, 32'd11);
      err_seen = 0;
      prbs_bits(100);
      chk1("t2_no_more_err", err_seen, 1'b0);
      chkn("t2_errcnt_hold", err_count_o, 32'd1);
      chkn("t2_bitcnt_111", bit_count_o, 32'd111);
      chk1("t2_still_locked", locked_o, 1'b1);

      // Three errors in each of two windows: lock kept
      for (int i = 0; i < 3; i++) begin next_prbs(b); step(~b, 1'b1); end
      prbs_bits(30);
      for (int i = 0; i < 3; i++) begin next_prbs(b); step(~b, 1'b1); end
      chk1("t4_spread_locked", locked_o, 1'b1);
      chkn("t4_spread_errcnt", err_count_o, 32'd7);
      chkn("t4_spread_bitcnt", bit_count_o, 32'd147);
      prbs_bits(50);

      // Clear on the same cycle as an errored bit
      clear_i = 1'b1;
      next_prbs(b);
      step(~b, 1'b1);
      clear_i = 1'b0;
      chk1("t6_clr_err_pulse", err_o, 1'b1);
      chkn("t6_clr_errcnt", err_count_o, 32'd0);
      chkn("t6_clr_bitcnt", bit_count_o, 32'd0);
      chk1("t6_clr_locked", locked_o, 1'b1);
      prbs_bits(70);
      chkn("t6_bitcnt_70", bit_count_o, 32'd70);

      // Four errors within ten bits: lock lost on the fourth
      for (int i = 0; i < 10; i++) begin
         next_prbs(b);
         step((i % 3 == 0) ? ~b : b, 1'b1);
         if (i == 8) chk1("t4_locked_after_3", locked_o, 1'b1);
      end
      chk1("t4_lost_lock", locked_o, 1'b0);
      chk1("t4_last_err", err_o, 1'b1);
      chkn("t4_errcnt_4", err_count_o, 32'd4);
      chkn("t4_bitcnt_80", bit_count_o, 32'd80);
      lock_seen = 0;
      prbs_bits(22);
      chk1("t4_relock_not_22", lock_seen, 1'b0);
      chkn("t4_errcnt_hold", err_count_o, 32'd4);
      chkn("t4_bitcnt_hold", bit_count_o, 32'd80);
      prbs_bits(1);
      chk1("t4_relock_23", locked_o, 1'b1);

      // valid_i toggling every cycle
      reset_i = 1'b1;
      #2;
      reset_i = 1'b0;
      lock_seen = 0; err_seen = 0; err_inval = 0;
      for (int c = 1; c <= 44; c++) begin
         if (c % 2 == 1) begin next_prbs(b); step(b, 1'b1); end
         else step(1'($urandom_range(0, 1)), 1'b0);
      end
      chk1("t5_nolock_44", lock_seen, 1'b0);
      next_prbs(b);
      step(b, 1'b1);
      chk1("t5_lock_45", locked_o, 1'b1);
      chkn("t5_bitcnt_0", bit_count_o, 32'd0);
      for (int c = 46; c <= 65; c++) begin
         if (c % 2 == 1) begin next_prbs(b); step(b, 1'b1); end
         else step(1'($urandom_range(0, 1)), 1'b0);
      end
      chkn("t5_bitcnt_10", bit_count_o, 32'd10);
      chk1("t5_no_err_invalid", err_inval, 1'b0);
      chk1("t5_no_err", err_seen, 1'b0);

      // Asynchronous reset mid-cycle while locked
      #2;
      reset_i = 1'b1;
      #1;
      chk1("t6_arst_locked", locked_o, 1'b0);
      chk1("t6_arst_err", err_o, 1'b0);
      chkn("t6_arst_bitcnt", bit_count_o, 32'd0);
      chkn("t6_arst_errcnt", err_count_o, 32'd0);
      #1;
      reset_i = 1'b0;
      lock_seen = 0;
      prbs_bits(22);
      chk1("t6_arst_nolock_22", lock_seen, 1'b0);
      prbs_bits(1);
      chk1("t6_arst_lock_23", locked_o, 1'b1);

      // Stuck-at-0 line never locks
      #2;
      reset_i = 1'b1;
      #2;
      reset_i = 1'b0;
      lock_seen = 0; err_seen = 0;
      for (int i = 0; i < 1000; i++) step(1'b0, 1'b1);
      chk1("t3_zero_nolock", lock_seen, 1'b0);
      chk1("t3_zero_noerr", err_seen, 1'b0);
      chkn("t3_zero_errcnt", err_count_o, 32'd0);
      chkn("t3_zero_bitcnt", bit_count_o, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
